// File: rtl/cache_backing_memory.sv
// Line-granular backing memory answering the cache memory-side handshake.
// Lines are moved one word per cycle through a single-port word array after LATENCY wait cycles.
module cache_backing_memory #(
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned BLOCK_SIZE = 128,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  mem_rd_en,
  input  logic                  mem_wr_en,
  input  logic [ADDR_SIZE-1:0]  mem_addr,
  input  logic [BLOCK_SIZE-1:0] mem_wr_data,
  output logic [BLOCK_SIZE-1:0] mem_rd_data,
  output logic                  mem_ack
);

  localparam int unsigned WORDS  = BLOCK_SIZE / DATA_SIZE;
  localparam int unsigned OFF    = $clog2(BLOCK_SIZE / 8);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned AW     = $clog2(DEPTH * WORDS);
  localparam int unsigned BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, ACK} state_t;

  state_t                state, next_state;
  logic                  is_write;
  logic [IDX_W-1:0]      idx;
  logic [BLOCK_SIZE-1:0] wr_line;
  logic [LAT_W-1:0]      lat_cnt;
  logic [BEAT_W-1:0]     beat;
  logic [AW-1:0]         word_addr;
  logic [DATA_SIZE-1:0]  mem [DEPTH*WORDS];
  logic                  accept;
  logic                  unused_addr;

  // Offset bits and bits above the index are intentionally dropped so addresses wrap.
  assign unused_addr = ^mem_addr;
  assign accept      = mem_wr_en | mem_rd_en;
  assign word_addr   = AW'(idx) * AW'(WORDS) + AW'(beat);
  assign mem_ack     = (state == ACK);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = (LATENCY == 0) ? XFER : WAIT;
      WAIT: if (lat_cnt == LAT_W'(LATENCY - 1)) next_state = XFER;
      XFER: if (beat == BEAT_W'(WORDS - 1)) next_state = ACK;
      ACK:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      idx         <= '0;
      wr_line     <= '0;
      lat_cnt     <= '0;
      beat        <= '0;
      mem_rd_data <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          lat_cnt <= '0;
          beat    <= '0;
          if (accept) begin
            is_write <= mem_wr_en;
            idx      <= mem_addr[OFF +: IDX_W];
            if (mem_wr_en) wr_line <= mem_wr_data;
          end
        end
        WAIT: lat_cnt <= lat_cnt + LAT_W'(1);
        XFER: begin
          beat <= (beat == BEAT_W'(WORDS - 1)) ? '0 : beat + BEAT_W'(1);
          if (!is_write) mem_rd_data[int'(beat)*DATA_SIZE +: DATA_SIZE] <= mem[word_addr];
        end
        default: ;
      endcase
    end
  end

  // Array is deliberately not reset; an async reset drops state to IDLE, which gates further writes.
  always_ff @(posedge clock) begin
    if (state == XFER && is_write)
      mem[word_addr] <= wr_line[int'(beat)*DATA_SIZE +: DATA_SIZE];
  end

endmodule

// File: tb/tb_cache_backing_memory.sv
// Directed bench for cache_backing_memory: default build and a LATENCY=0 build side by side,
// with read expectations queued at request time and compared when mem_ack arrives.
module tb_cache_backing_memory;

  logic         clock;
  logic         reset_n;
  logic         rd_en   [2];
  logic         wr_en   [2];
  logic [31:0]  addr    [2];
  logic [127:0] wdata   [2];
  logic [127:0] rd_data [2];
  logic         ack     [2];

  int checks = 0;
  int errors = 0;

  logic [127:0] model [int];
  logic [127:0] sb0 [$];
  logic [127:0] sb1 [$];
  logic [127:0] last_rd [2];

  cache_backing_memory dut (
    .clock(clock), .reset_n(reset_n),
    .mem_rd_en(rd_en[0]), .mem_wr_en(wr_en[0]), .mem_addr(addr[0]),
    .mem_wr_data(wdata[0]), .mem_rd_data(rd_data[0]), .mem_ack(ack[0])
  );

  cache_backing_memory #(.LATENCY(0)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .mem_rd_en(rd_en[1]), .mem_wr_en(wr_en[1]), .mem_addr(addr[1]),
    .mem_wr_data(wdata[1]), .mem_rd_data(rd_data[1]), .mem_ack(ack[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input int w, input logic [127:0] line);
    if (w == 0) sb0.push_back(line); else sb1.push_back(line);
  endtask

  task automatic sb_check(input int w, input string tag);
    logic [127:0] e;
    int n;
    n = (w == 0) ? sb0.size() : sb1.size();
    if (n == 0) begin
      chk({tag, "_sb_empty"}, 128'(n), 128'd1);
    end else begin
      e = (w == 0) ? sb0.pop_front() : sb1.pop_front();
      for (int s = 0; s < 4; s++)
        chk($sformatf("%s_w%0d", tag, s), 128'(rd_data[w][s*32 +: 32]), 128'(e[s*32 +: 32]));
    end
    last_rd[w] = rd_data[w];
  endtask

  // Starts 1 time unit after a rising edge (cycle 0) and returns at the same phase.
  task automatic op(input int w, input bit wr, input bit rd, input logic [31:0] a,
                    input logic [127:0] d, input int exp_cyc, input string tag);
    int k;
    bit got;
    int key;
    key = w * 256 + int'((a >> 4) & 32'hFF);
    if (wr) model[key] = d;
    else sb_push(w, model[key]);
    wr_en[w] = wr; rd_en[w] = rd; addr[w] = a; wdata[w] = d;
    k = 0; got = 0;
    while (!got && k < 40) begin
      @(negedge clock);
      if (ack[w]) got = 1;
      else begin @(posedge clock); #1; k++; end
    end
    chk({tag, "_ack_cycle"}, 128'(k), 128'(exp_cyc));
    if (got) begin
      if (wr) chk({tag, "_rd_data_kept"}, rd_data[w], last_rd[w]);
      else sb_check(w, tag);
    end
    @(posedge clock); #1;
    wr_en[w] = 0; rd_en[w] = 0;
    @(negedge clock);
    chk({tag, "_ack_pulse"}, 128'(ack[w]), 128'd0);
    @(posedge clock); #1;
  endtask

  localparam logic [127:0] L5   = 128'h55555555_AAAAAAAA_12345678_9ABCDEF0;
  localparam logic [127:0] D30  = 128'h0123456789ABCDEF_0123456789ABCDEF;
  localparam logic [127:0] D40  = 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE;
  localparam logic [127:0] OLD  = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D20  = 128'h99990000_AAAA1111_BBBB2222_CCCC3333;
  localparam logic [127:0] B0   = 128'h0000000A_0000000B_0000000C_0000000D;
  localparam logic [127:0] B1   = 128'hF0F0F0F0_0F0F0F0F_A5A5A5A5_5A5A5A5A;

  initial begin
    logic [127:0] merged;
    int n;
    int first_ack, second_ack;
    bit switched;
    reset_n = 0;
    for (int i = 0; i < 2; i++) begin
      rd_en[i] = 0; wr_en[i] = 0; addr[i] = '0; wdata[i] = '0; last_rd[i] = '0;
    end
    repeat (3) @(posedge clock);
    #1 reset_n = 1;
    chk("reset_ack", 128'(ack[0]), 128'd0);
    chk("reset_rd_data", rd_data[0], '0);
    chk("reset_ack_l0", 128'(ack[1]), 128'd0);
    chk("reset_rd_data_l0", rd_data[1], '0);

    op(0, 1, 0, 32'h50, L5, 7, "wr_line5");
    op(0, 0, 1, 32'h50, '0, 7, "rd_line5");
    op(0, 1, 0, 32'h30, D30, 7, "wr_30");
    op(0, 0, 1, 32'h30, '0, 7, "rd_30");
    op(0, 1, 1, 32'h40, D40, 7, "both_40");
    op(0, 0, 1, 32'h40, '0, 7, "rd_40");
    op(0, 0, 1, 32'h1050, '0, 7, "rd_alias_1050");
    op(0, 0, 1, 32'h5C, '0, 7, "rd_offset_5c");

    op(1, 1, 0, 32'h100, B0, 5, "l0_wr_a");
    op(1, 1, 0, 32'h110, B1, 5, "l0_wr_b");
    op(1, 0, 1, 32'h100, '0, 5, "l0_rd_a");

    // Back-to-back reads: enable held high through the first ack; address switched at cycle 6.
    rd_en[1] = 1; addr[1] = 32'h110; sb_push(1, model[256 + 17]);
    n = 0; first_ack = -1; second_ack = -1; switched = 0;
    for (int k = 0; k < 30 && n < 2; k++) begin
      @(negedge clock);
      if (ack[1]) begin
        n++;
        if (n == 1) first_ack = k; else second_ack = k;
        sb_check(1, (n == 1) ? "b2b_first" : "b2b_second");
      end
      @(posedge clock); #1;
      if (n == 1 && !switched) begin
        addr[1] = 32'h100; sb_push(1, model[256 + 16]); switched = 1;
      end
      if (n == 2) rd_en[1] = 0;
    end
    rd_en[1] = 0;
    chk("b2b_first_ack_cycle", 128'(first_ack), 128'd5);
    chk("b2b_second_ack_cycle", 128'(second_ack), 128'd11);

    // Reset asserted during beat 2 of a write: words 0-1 committed, 2-3 keep old data.
    op(0, 1, 0, 32'h20, OLD, 7, "wr_20_old");
    wr_en[0] = 1; addr[0] = 32'h20; wdata[0] = D20;
    repeat (5) @(posedge clock);
    #2;
    reset_n = 0; wr_en[0] = 0;
    #1;
    chk("midrst_ack", 128'(ack[0]), 128'd0);
    chk("midrst_rd_data", rd_data[0], '0);
    @(negedge clock);
    reset_n = 1;
    last_rd[0] = '0; last_rd[1] = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("midrst_no_ack_%0d", k), 128'(ack[0]), 128'd0);
    end
    @(posedge clock); #1;
    merged = {OLD[127:64], D20[63:0]};
    model[2] = merged;
    op(0, 0, 1, 32'h20, '0, 7, "rd_20_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
